demux_1to4: RTL and testbench



---
 rtl/demux_1to4_pkg.sv | 22 ++
 rtl/demux_1to4_dec.sv | 14 +
 rtl/demux_1to4.sv | 63 ++++++
 tb/tb_demux_1to4.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/demux_1to4_pkg.sv
// Shared constants, select type and one-hot helper for the clocked 1-to-4 demultiplexer.
package demux_1to4_pkg;

    localparam int SEL_W = 2;
    localparam int N_OUT = 4;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [N_OUT-1:0] sel_to_onehot(input sel_t sel);
        logic [N_OUT-1:0] oh;
        oh = 4'b0000;
        case (sel)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_1to4_dec.sv
// Combinational 2-to-4 one-hot decoder for the demultiplexer lane select.
module demux_1to4_dec
    import demux_1to4_pkg::*;
(
    input  sel_t             s,
    output logic [N_OUT-1:0] dec
);

    // one-hot decode of the lane select
    always_comb begin
        dec = sel_to_onehot(s);
    end

endmodule

// File: rtl/demux_1to4.sv
// Clocked 1-to-4 demultiplexer with registered lanes and one-hot select copy.
// Build option: define DEMUX_1TO4_HOLD_EN to let unselected lanes keep their value on a load.
module demux_1to4
    import demux_1to4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [WIDTH-1:0]       i,
    input  sel_t                   s,
    output logic [N_OUT*WIDTH-1:0] y,
    output logic [N_OUT-1:0]       sel_oh
);

    logic [N_OUT-1:0]       dec_s;
    logic [N_OUT*WIDTH-1:0] y_next_s;
    logic [N_OUT*WIDTH-1:0] y_r;
    logic [N_OUT-1:0]       sel_oh_r;

    demux_1to4_dec u_dec (
        .s   (s),
        .dec (dec_s)
    );

    // per-lane next value: selected lane takes i, others clear or hold by build
    always_comb begin
        y_next_s = y_r;
        for (int k = 0; k < N_OUT; k++) begin
            if (dec_s[k]) begin
                y_next_s[k*WIDTH +: WIDTH] = i;
            end else begin
`ifdef DEMUX_1TO4_HOLD_EN
                y_next_s[k*WIDTH +: WIDTH] = y_r[k*WIDTH +: WIDTH];
`else
                y_next_s[k*WIDTH +: WIDTH] = '0;
`endif
            end
        end
    end

    // output registers, cleared asynchronously and loaded only on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r      <= '0;
            sel_oh_r <= 4'b0000;
        end else if (en) begin
            y_r      <= y_next_s;
            sel_oh_r <= dec_s;
        end else begin
            y_r      <= y_r;
            sel_oh_r <= sel_oh_r;
        end
    end

    assign y      = y_r;
    assign sel_oh = sel_oh_r;

    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(s))
        else $error("select contains X/Z while enabled");

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against a lane-array model plus literal expectations.
module tb_demux_1to4;

`ifdef DEMUX_1TO4_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        i1;
    logic [7:0]  i8;
    logic [1:0]  s;
    logic [3:0]  y1;
    logic [3:0]  oh1;
    logic [31:0] y8;
    logic [3:0]  oh8;

    int checks;
    int errors;

    logic [3:0]  m_y1;
    logic [31:0] m_y8;
    logic [3:0]  m_oh;

    demux_1to4 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i1), .s(s), .y(y1), .sel_oh(oh1)
    );

    demux_1to4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i8), .s(s), .y(y8), .sel_oh(oh8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // lane model: the selected lane takes the data, the rest clear (or keep in the hold build)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y1 <= 4'b0000;
            m_y8 <= 32'h0;
            m_oh <= 4'b0000;
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (int'(s) == k) begin
                    m_y1[k]        <= i1;
                    m_y8[k*8 +: 8] <= i8;
                end else if (!HOLD) begin
                    m_y1[k]        <= 1'b0;
                    m_y8[k*8 +: 8] <= 8'h00;
                end
            end
            m_oh <= 4'b0001 << s;
        end
    end

    // every falling edge: both instances against the model
    always @(negedge clk) begin
        check("model_y1",  {28'd0, y1},  {28'd0, m_y1});
        check("model_oh1", {28'd0, oh1}, {28'd0, m_oh});
        check("model_y8",  y8,           m_y8);
        check("model_oh8", {28'd0, oh8}, {28'd0, m_oh});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sweep_exp [4];
        logic [7:0] data8 [4];
        sweep_exp[0] = 4'b0001; sweep_exp[1] = 4'b0010;
        sweep_exp[2] = 4'b0100; sweep_exp[3] = 4'b1000;
        data8[0] = 8'h11; data8[1] = 8'h3C; data8[2] = 8'hF0; data8[3] = 8'h81;
        checks = 0;
        errors = 0;

        // reset held with live inputs and running clock
        rst_n = 1'b0; en = 1'b1; i1 = 1'b1; i8 = 8'hFF; s = 2'd3;
        repeat (3) step();
        check("rst_y1",  {28'd0, y1},  32'h0);
        check("rst_oh1", {28'd0, oh1}, 32'h0);
        check("rst_y8",  y8,           32'h0);
        rst_n = 1'b1;

        // sweep, one lane per cycle, data on all lanes of the wide instance
        for (int k = 0; k < 4; k++) begin
            s = 2'(k); i1 = 1'b1; i8 = data8[k];
            step();
            check("oh_sweep", {28'd0, oh1}, {28'd0, sweep_exp[k]});
            if (!HOLD) check("y_sweep", {28'd0, y1}, {28'd0, sweep_exp[k]});
        end

        // enable low holds outputs for three cycles
        s = 2'd2; i1 = 1'b1;
        step();
        en = 1'b0; s = 2'd0; i1 = 1'b0; i8 = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_oh", {28'd0, oh1}, 32'h4);
            if (!HOLD) check("hold_y", {28'd0, y1}, 32'h4);
        end
        en = 1'b1;

        // zero data on selected lane
        s = 2'd1; i1 = 1'b1;
        step();
        i1 = 1'b0;
        step();
        check("zero_oh", {28'd0, oh1}, 32'h2);
        if (!HOLD) check("zero_y", {28'd0, y1}, 32'h0);

        // fresh reset, then hold-build accumulation or default single-lane result
        #2 rst_n = 1'b0;
        #1 check("midrst_y1", {28'd0, y1}, 32'h0);
        check("midrst_oh", {28'd0, oh1}, 32'h0);
        step();
        rst_n = 1'b1;
        i1 = 1'b1; s = 2'd0;
        step();
        check("acc_y0", {28'd0, y1}, 32'h1);
        s = 2'd3;
        step();
        check("acc_y1", {28'd0, y1}, HOLD ? 32'h9 : 32'h8);

        // wide data after reset
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        i8 = 8'hA5; s = 2'd2; i1 = 1'b1;
        step();
        check("wide_y8",  y8,           32'h00A5_0000);
        check("wide_oh8", {28'd0, oh8}, 32'h4);

        // reset in the middle of a stream discards loaded data
        s = 2'd3; i8 = 8'h7E;
        step();
        check("stream_y8", y8, HOLD ? 32'h7EA5_0000 : 32'h7E00_0000);
        #2 rst_n = 1'b0;
        #1 check("stream_rst_y8", y8, 32'h0);
        check("stream_rst_oh", {28'd0, oh8}, 32'h0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
